// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared constants for the ARM execute stage: ALU command
//               encodings, shift-type codes, forwarding-select codes and
//               status-register bit positions, plus a rotate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

  // ALU command encodings (exe_cmd)
  localparam logic [3:0] c_CMD_MOV = 4'b0001;
  localparam logic [3:0] c_CMD_MVN = 4'b1001;
  localparam logic [3:0] c_CMD_ADD = 4'b0010;  // also LDR / STR address
  localparam logic [3:0] c_CMD_ADC = 4'b0011;
  localparam logic [3:0] c_CMD_SUB = 4'b0100;  // also CMP
  localparam logic [3:0] c_CMD_SBC = 4'b0101;
  localparam logic [3:0] c_CMD_AND = 4'b0110;  // also TST
  localparam logic [3:0] c_CMD_ORR = 4'b0111;
  localparam logic [3:0] c_CMD_EOR = 4'b1000;

  // Shift types, shift_operand[6:5]
  localparam logic [1:0] c_SHIFT_LSL = 2'b00;
  localparam logic [1:0] c_SHIFT_LSR = 2'b01;
  localparam logic [1:0] c_SHIFT_ASR = 2'b10;
  localparam logic [1:0] c_SHIFT_ROR = 2'b11;

  // Forwarding selects; 2'b11 falls back to the register value
  localparam logic [1:0] c_FWD_REG = 2'b00;
  localparam logic [1:0] c_FWD_MEM = 2'b01;
  localparam logic [1:0] c_FWD_WB  = 2'b10;

  // Status register bit positions, {N,Z,C,V}
  localparam int c_STATUS_N = 3;
  localparam int c_STATUS_Z = 2;
  localparam int c_STATUS_C = 1;
  localparam int c_STATUS_V = 0;

  // 32-bit rotate right; an amount of 0 returns the value unchanged
  // because the left shift by 32 yields zero.
  function automatic logic [31:0] ror32(input logic [31:0] i_val,
                                        input logic [4:0]  i_amt);
    logic [5:0] w_left;
    w_left = 6'd32 - {1'b0, i_amt};
    return (i_val >> i_amt) | (i_val << w_left);
  endfunction

endpackage : arm_pkg
`default_nettype wire

// File: rtl/val2_generator.sv
`default_nettype none
// ============================================================================
// Module      : val2_generator
// Description : Combinational second-operand generator.
//               Memory ops   -> zero-extended 12-bit offset
//               Immediate    -> 8-bit value rotated right by 2*rot
//               Register     -> op2reg shifted LSL/LSR/ASR/ROR by 5-bit amount
// Ports       : i_op2reg        forwarded Rm value
//               i_shift_operand 12-bit operand field
//               i_imm           immediate-mode flag
//               i_mem_op        load/store in flight
//               o_val2          generated operand
// Revision    : 1.0 - initial release
// ============================================================================
module val2_generator
  import arm_pkg::*;
(
  input  logic [31:0] i_op2reg,
  input  logic [11:0] i_shift_operand,
  input  logic        i_imm,
  input  logic        i_mem_op,
  output logic [31:0] o_val2
);

  logic [4:0]  w_rot_amt;
  logic [4:0]  w_shift_amt;
  logic [1:0]  w_shift_type;
  logic [31:0] w_imm_val;
  logic [31:0] w_shift_val;

  assign w_rot_amt    = {i_shift_operand[11:8], 1'b0};
  assign w_shift_amt  = i_shift_operand[11:7];
  assign w_shift_type = i_shift_operand[6:5];
  assign w_imm_val    = ror32({24'b0, i_shift_operand[7:0]}, w_rot_amt);

  always_comb begin
    w_shift_val = i_op2reg;
    case (w_shift_type)
      c_SHIFT_LSL: w_shift_val = i_op2reg << w_shift_amt;
      c_SHIFT_LSR: w_shift_val = i_op2reg >> w_shift_amt;
      c_SHIFT_ASR: w_shift_val = 32'($signed(i_op2reg) >>> w_shift_amt);
      c_SHIFT_ROR: w_shift_val = ror32(i_op2reg, w_shift_amt);
      default:     w_shift_val = i_op2reg;
    endcase
  end

  always_comb begin
    if (i_mem_op)
      o_val2 = {20'b0, i_shift_operand};
    else if (i_imm)
      o_val2 = w_imm_val;
    else
      o_val2 = w_shift_val;
  end

endmodule : val2_generator
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage
// Description : ARM pipeline execute stage. Holds the ID/EXE register,
//               forwarding muxes, Val2 generation, ALU, {N,Z,C,V} status
//               register and branch-target adder.
// Ports       : clk, rst (sync, active-high), freeze (stall)
//               decode inputs : pc_in, controls, exe_cmd, indices, operands,
//                               shift_operand, signed_imm_24
//               forwarding    : sel_src1/2, mem_fwd, wb_fwd
//               outputs       : alu_result, store_value, dest/src indices,
//                               enables, branch_taken/addr, status_reg
// Revision    : 1.0 - initial release
// ============================================================================
module exe_stage
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic        wb_en,
  input  logic        b,
  input  logic        s,
  input  logic        imm,
  input  logic [3:0]  exe_cmd,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic [3:0]  dest,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm_24,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] mem_fwd,
  input  logic [31:0] wb_fwd,
  output logic [31:0] alu_result,
  output logic [31:0] store_value,
  output logic [3:0]  dest_out,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status_reg
);

  // ID/EXE pipeline register
  logic [31:0] r_pc;
  logic        r_mem_r_en, r_mem_w_en, r_wb_en, r_b, r_s, r_imm;
  logic [3:0]  r_exe_cmd, r_src1, r_src2, r_dest;
  logic [31:0] r_val_rn, r_val_rm;
  logic [11:0] r_shift_operand;
  logic [23:0] r_signed_imm_24;
  logic [3:0]  r_status;

  // Inside the capture branch freeze is already 0, so a taken branch in
  // EXE (r_b) is exactly the flush condition: its shadow loses all controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc            <= '0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_wb_en         <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_imm           <= 1'b0;
      r_exe_cmd       <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
      r_dest          <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
    end else if (!freeze) begin
      r_pc            <= pc_in;
      r_mem_r_en      <= mem_r_en & ~r_b;
      r_mem_w_en      <= mem_w_en & ~r_b;
      r_wb_en         <= wb_en    & ~r_b;
      r_b             <= b        & ~r_b;
      r_s             <= s        & ~r_b;
      r_imm           <= imm;
      r_exe_cmd       <= exe_cmd;
      r_src1          <= src1;
      r_src2          <= src2;
      r_dest          <= dest;
      r_val_rn        <= val_rn;
      r_val_rm        <= val_rm;
      r_shift_operand <= shift_operand;
      r_signed_imm_24 <= signed_imm_24;
    end
  end

  // Forwarding muxes
  logic [31:0] w_op1, w_op2reg, w_val2;

  always_comb begin
    case (sel_src1)
      c_FWD_MEM: w_op1 = mem_fwd;
      c_FWD_WB:  w_op1 = wb_fwd;
      default:   w_op1 = r_val_rn;
    endcase
    case (sel_src2)
      c_FWD_MEM: w_op2reg = mem_fwd;
      c_FWD_WB:  w_op2reg = wb_fwd;
      default:   w_op2reg = r_val_rm;
    endcase
  end

  val2_generator u_val2_generator (
    .i_op2reg        (w_op2reg),
    .i_shift_operand (r_shift_operand),
    .i_imm           (r_imm),
    .i_mem_op        (r_mem_r_en | r_mem_w_en),
    .o_val2          (w_val2)
  );

  // ALU. Add and subtract share one 33-bit adder: subtraction feeds ~val2
  // with carry-in 1 (SUB) or C (SBC), so bit 32 is directly NOT-borrow.
  logic [31:0] w_add_b;
  logic        w_add_cin;
  logic [32:0] w_sum;
  logic [31:0] w_result;
  logic        w_valid;
  logic        w_arith;
  logic [3:0]  w_status_next;

  assign w_sum = {1'b0, w_op1} + {1'b0, w_add_b} + {32'b0, w_add_cin};

  always_comb begin
    w_add_b   = w_val2;
    w_add_cin = 1'b0;
    w_result  = '0;
    w_valid   = 1'b1;
    w_arith   = 1'b0;
    case (r_exe_cmd)
      c_CMD_MOV: w_result = w_val2;
      c_CMD_MVN: w_result = ~w_val2;
      c_CMD_ADD: begin
        w_arith  = 1'b1;
        w_result = w_sum[31:0];
      end
      c_CMD_ADC: begin
        w_add_cin = r_status[c_STATUS_C];
        w_arith   = 1'b1;
        w_result  = w_sum[31:0];
      end
      c_CMD_SUB: begin
        w_add_b   = ~w_val2;
        w_add_cin = 1'b1;
        w_arith   = 1'b1;
        w_result  = w_sum[31:0];
      end
      c_CMD_SBC: begin
        w_add_b   = ~w_val2;
        w_add_cin = r_status[c_STATUS_C];
        w_arith   = 1'b1;
        w_result  = w_sum[31:0];
      end
      c_CMD_AND: w_result = w_op1 & w_val2;
      c_CMD_ORR: w_result = w_op1 | w_val2;
      c_CMD_EOR: w_result = w_op1 ^ w_val2;
      default:   w_valid  = 1'b0;
    endcase
  end

  always_comb begin
    w_status_next = r_status;
    if (w_valid) begin
      w_status_next[c_STATUS_N] = w_result[31];
      w_status_next[c_STATUS_Z] = (w_result == 32'b0);
      if (w_arith) begin
        w_status_next[c_STATUS_C] = w_sum[32];
        // Overflow: both adder inputs share a sign that the result lacks
        w_status_next[c_STATUS_V] = (w_op1[31] == w_add_b[31]) &&
                                    (w_result[31] != w_op1[31]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_status <= '0;
    else if (r_s && !freeze)
      r_status <= w_status_next;
  end

  assign alu_result   = w_result;
  assign store_value  = w_op2reg;
  assign dest_out     = r_dest;
  assign src1_out     = r_src1;
  assign src2_out     = r_src2;
  assign wb_en_out    = r_wb_en;
  assign mem_r_en_out = r_mem_r_en;
  assign mem_w_en_out = r_mem_w_en;
  assign branch_taken = r_b;
  assign branch_addr  = r_pc + {{6{r_signed_imm_24[23]}}, r_signed_imm_24, 2'b00};
  assign status_reg   = r_status;

endmodule : exe_stage
`default_nettype wire

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline, directly downstream of the instruction-decode stage. It owns the ID/EXE pipeline register, operand forwarding muxes, the second-operand (Val2) generator, the ALU, the architectural status register {N,Z,C,V} and branch-target generation. It feeds combinational results to the EXE/MEM register, branch redirect to fetch, and `status_reg` back to decode's condition check.

## Interface
- No parameters; data width fixed at 32, register index at 4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `freeze` in 1: hold ID/EXE register and status register (memory stall).
- `pc_in` in 32: PC+4 of the decoded instruction.
- `mem_r_en`, `mem_w_en`, `wb_en`, `b`, `s`, `imm` in 1 each: decode controls (already bubbled by decode).
- `exe_cmd` in 4: ALU command.
- `src1`, `src2`, `dest` in 4: register indices.
- `val_rn`, `val_rm` in 32: register-file operands.
- `shift_operand` in 12; `signed_imm_24` in 24.
- `sel_src1`, `sel_src2` in 2: forwarding select, 00 = register, 01 = `mem_fwd`, 10 = `wb_fwd`, 11 = register.
- `mem_fwd`, `wb_fwd` in 32: forwarded values.
- `alu_result` out 32; `store_value` out 32 (forwarded Rm/Rd for STR).
- `dest_out`, `src1_out`, `src2_out` out 4 (for the forwarding unit).
- `wb_en_out`, `mem_r_en_out`, `mem_w_en_out` out 1.
- `branch_taken` out 1; `branch_addr` out 32; `status_reg` out 4 ({N,Z,C,V}, bit 3 = N).

## Operation
- ID/EXE register: all inputs captured at the rising edge unless frozen. Priority: `rst` > `freeze` (hold everything) > flush > capture.
- Flush: when `branch_taken` = 1 and not frozen, the next edge loads control bits (`wb_en`, `mem_r_en`, `mem_w_en`, `b`, `s`) as 0; data fields are don't-care.
- Forwarding: op1 = mux(`sel_src1`) over registered `val_rn`; op2reg = mux(`sel_src2`) over registered `val_rm`; `store_value` = op2reg.
- Val2, in priority order:
  - memory op (`mem_r_en_q` | `mem_w_en_q`): zero-extended `shift_operand[11:0]`.
  - `imm_q` = 1: `{24'b0, so[7:0]}` rotated right by 2*`so[11:8]`.
  - otherwise: op2reg shifted by `so[11:7]` per `so[6:5]`: 00 LSL, 01 LSR, 10 ASR, 11 ROR; amount 0 passes unchanged.
- ALU by `exe_cmd`:
  - 0001 MOV = val2; 1001 MVN = ~val2.
  - 0010 ADD / LDR / STR = op1+val2; 0011 ADC = op1+val2+C.
  - 0100 SUB / CMP = op1−val2; 0101 SBC = op1−val2−~C.
  - 0110 AND / TST; 0111 ORR; 1000 EOR.
  - any other code gives result 0 and flags unchanged.
- Flags: N = result[31]; Z = (result == 0).
  - C = carry-out of the 33-bit add, or NOT borrow for subtract; unchanged for logical/move ops.
  - V = signed overflow for add/sub; unchanged otherwise.
- `status_reg` updated at the edge ending the EXE cycle iff `s_q` = 1 and `freeze` = 0.
- `branch_taken` = `b_q`; `branch_addr` = `pc_q` + (sign-extended `signed_imm_24_q` << 2), 32-bit wrap.

## Timing
- Latency: one edge from decode outputs to EXE results. `alu_result`, `branch_*` and enable outputs are combinational from the ID/EXE register; `status_reg` is registered.
- Reset: all ID/EXE fields 0, `status_reg` = 0000. All outputs 0 except `branch_addr`, which equals sign-extended 0 + `pc_q` = 0.
- ADC/SBC use `status_reg` as registered before the current instruction, so back-to-back flag use is exact.
- Freeze while `branch_taken` = 1: branch stays asserted for every frozen cycle and is flushed on the first unfrozen edge.
- `rst` during a freeze or flush clears state on that edge.

## Structure
- Shared package `arm_pkg` holds:
  - `exe_cmd` constants;
  - shift-type codes;
  - forwarding-select codes;
  - status bit indices (N = 3, Z = 2, C = 1, V = 0).
- Sub-module `val2_generator` (purely combinational): inputs op2reg, `shift_operand`, `imm`, mem-op flag; output val2.
- ALU, status register, pipeline register and forwarding logic live in `exe_stage`.

## Test plan
- Immediate rotate: `imm` = 1, `shift_operand` = 0x1FF, ADD, `val_rn` = 1 → `alu_result` = 0xC0000040 one edge later.
- SUBS: `val_rn` = 5, `val_rm` = 5, `s` = 1 → result 0; `status_reg` = 0110 after the following edge.
- CMP overflow then ADC:
  - CMP 0x7FFFFFFF vs 0xFFFFFFFF → `status_reg` = 1001.
  - Next ADC 1+1 → result 2, using C = 0.
- Branch: `b` = 1, `pc_in` = 0x100, `signed_imm_24` = 0xFFFFFE → `branch_taken` = 1, `branch_addr` = 0xF8. The next captured instruction shows all enables 0.
- Freeze: load ADD, then assert `freeze` 3 cycles while changing inputs → outputs stable. A pending SUBS flag update is deferred until `freeze` drops.
- Forwarding: `sel_src1` = 01, `mem_fwd` = 0x10, `sel_src2` = 10, `wb_fwd` = 0x20, ADD register mode, shift 0 → `alu_result` = 0x30.
